// File: rtl/mem_io_sequencer_if.sv
// Bus bundle between the control unit / board and the SRAM + I/O sequencer.
// The sequencer uses the slave modport; the control unit, board and SRAM
// side use the master modport.
interface mem_io_sequencer_if;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [19:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Data_valid;
    logic [15:0] Switches;
    logic [15:0] HEX_data;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;

    modport master (
        output Mem_OE, Mem_WE, ADDR, Data_from_CPU, Switches, SRAM_DQ_in,
        input  Data_to_CPU, Data_valid, HEX_data, SRAM_ADDR, SRAM_CE_N,
               SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );

    modport slave (
        input  Mem_OE, Mem_WE, ADDR, Data_from_CPU, Switches, SRAM_DQ_in,
        output Data_to_CPU, Data_valid, HEX_data, SRAM_ADDR, SRAM_CE_N,
               SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );
endinterface

// File: rtl/mem_io_sequencer.sv
// Sequences async SRAM strobes for control-unit memory requests and decodes a
// single memory-mapped I/O word (switch read / hex-display write).
// Every output comes straight from a register; the comb process computes the
// next value of each register, so strobes change only on clock edges.
module mem_io_sequencer #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
    input logic          Clk,
    input logic          Reset,
    mem_io_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, DONE} state_t;

    localparam logic [2:0] LAST_COUNT = 3'(WAIT_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  count, count_next;
    logic        io_hit, io_hit_next;
    logic [19:0] addr, addr_next;
    logic [15:0] wdata, wdata_next;
    logic [15:0] rdata, rdata_next;
    logic        valid, valid_next;
    logic [15:0] hex, hex_next;
    logic        ce_n, ce_n_next;
    logic        oe_n, oe_n_next;
    logic        we_n, we_n_next;
    logic        dq_oe, dq_oe_next;
    logic        req_hit;

    assign req_hit = (bus.ADDR == IO_ADDR);

    // State and output registers; reset drops every strobe and the bus drive at once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            count  <= '0;
            io_hit <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            rdata  <= '0;
            valid  <= 1'b0;
            hex    <= '0;
            ce_n   <= 1'b1;
            oe_n   <= 1'b1;
            we_n   <= 1'b1;
            dq_oe  <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            io_hit <= io_hit_next;
            addr   <= addr_next;
            wdata  <= wdata_next;
            rdata  <= rdata_next;
            valid  <= valid_next;
            hex    <= hex_next;
            ce_n   <= ce_n_next;
            oe_n   <= oe_n_next;
            we_n   <= we_n_next;
            dq_oe  <= dq_oe_next;
        end
    end

    // Next state plus next strobe values; strobes default to idle every cycle
    always_comb begin
        state_next  = state;
        count_next  = count;
        io_hit_next = io_hit;
        addr_next   = addr;
        wdata_next  = wdata;
        rdata_next  = rdata;
        valid_next  = 1'b0;
        hex_next    = hex;
        ce_n_next   = 1'b1;
        oe_n_next   = 1'b1;
        we_n_next   = 1'b1;
        dq_oe_next  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.Mem_WE) begin
                    addr_next   = bus.ADDR;
                    wdata_next  = bus.Data_from_CPU;
                    io_hit_next = req_hit;
                    count_next  = '0;
                    state_next  = WR;
                    ce_n_next   = req_hit;
                    we_n_next   = req_hit;
                    dq_oe_next  = ~req_hit;
                end else if (bus.Mem_OE) begin
                    addr_next   = bus.ADDR;
                    io_hit_next = req_hit;
                    count_next  = '0;
                    state_next  = RD;
                    ce_n_next   = req_hit;
                    oe_n_next   = req_hit;
                end
            end
            RD: begin
                if (count == LAST_COUNT) begin
                    rdata_next = io_hit ? bus.Switches : bus.SRAM_DQ_in;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else begin
                    count_next = count + 3'd1;
                    ce_n_next  = io_hit;
                    oe_n_next  = io_hit;
                end
            end
            WR: begin
                ce_n_next  = io_hit;
                dq_oe_next = ~io_hit;
                if (count == LAST_COUNT) begin
                    if (io_hit) begin
                        hex_next = wdata;
                    end
                    state_next = WR_HOLD;
                end else begin
                    count_next = count + 3'd1;
                    we_n_next  = io_hit;
                end
            end
            WR_HOLD: begin
                state_next = DONE;
            end
            DONE: begin
                if (!bus.Mem_OE && !bus.Mem_WE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.SRAM_ADDR   = addr;
    assign bus.SRAM_CE_N   = ce_n;
    assign bus.SRAM_UB_N   = ce_n;
    assign bus.SRAM_LB_N   = ce_n;
    assign bus.SRAM_OE_N   = oe_n;
    assign bus.SRAM_WE_N   = we_n;
    assign bus.SRAM_DQ_out = wdata;
    assign bus.SRAM_DQ_oe  = dq_oe;
    assign bus.Data_to_CPU = rdata;
    assign bus.Data_valid  = valid;
    assign bus.HEX_data    = hex;

endmodule

// File: doc/mem_io_sequencer.md
Name: mem_io_sequencer

Overview:
- Sits between the control unit's memory strobes (Mem_OE/Mem_WE, active-high, held for multiple cycles per access) and the external asynchronous 16-bit SRAM plus board I/O.
- Sequences SRAM chip-select, output-enable and write-enable with a programmable wait count, and tri-state control of the data bus.
- Captures read data for the MDR.
- Decodes one memory-mapped I/O address: reads return the switches; writes update the hex-display register.

Parameters:
WAIT_CYCLES, 2, cycles SRAM_OE_N / SRAM_WE_N held low per access (legal range 1..7)
IO_ADDR, 20'h0FFFF, memory-mapped I/O address (switches read / hex write)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
Mem_OE  in  1  read request from control unit, level
Mem_WE  in  1  write request from control unit, level
ADDR  in  20  address from MAR (zero-extended)
Data_from_CPU  in  16  write data from MDR
Data_to_CPU  out  16  captured read data to MDR input mux
Data_valid  out  1  one-cycle pulse, read data captured
Switches  in  16  board switches
HEX_data  out  16  hex-display register
SRAM_ADDR  out  20  SRAM address
SRAM_CE_N  out  1  chip enable, active-low
SRAM_UB_N  out  1  upper byte enable, active-low
SRAM_LB_N  out  1  lower byte enable, active-low
SRAM_OE_N  out  1  output enable, active-low
SRAM_WE_N  out  1  write enable, active-low
SRAM_DQ_in  in  16  SRAM data bus, input side
SRAM_DQ_out  out  16  SRAM data bus, output side
SRAM_DQ_oe  out  1  1 = drive SRAM_DQ_out onto bus

Behaviour:
- Reset values:
  - Data_to_CPU = 0, Data_valid = 0, HEX_data = 0, SRAM_ADDR = 0, SRAM_DQ_out = 0.
  - All *_N outputs = 1; SRAM_DQ_oe = 0.
  - State = IDLE; wait counter = 0.
- Reset mid-access deasserts every strobe and the bus drive at that same edge. No partial write completes after the edge.
- All SRAM_* outputs and Data_* outputs are registered. SRAM_UB_N and SRAM_LB_N always equal SRAM_CE_N (word access only).
- States: IDLE, RD, WR, WR_HOLD, DONE.
- IDLE:
  - Mem_WE = 1: latch ADDR and Data_from_CPU, go to WR. Write wins if Mem_OE = 1 in the same cycle.
  - Else Mem_OE = 1: latch ADDR, go to RD.
  - Counter cleared on entry to RD/WR.
- I/O detect: io_hit = (latched address == IO_ADDR). When io_hit is set, CE_N/OE_N/WE_N stay 1 and DQ_oe stays 0 for the whole access. Timing is identical to an SRAM access.
- RD:
  - CE_N = 0, OE_N = 0, unless io_hit.
  - Counter increments each cycle.
  - At the edge where counter == WAIT_CYCLES-1:
    - Data_to_CPU <= io_hit ? Switches : SRAM_DQ_in.
    - Data_valid <= 1 for exactly one cycle.
    - Go to DONE; CE_N/OE_N return to 1.
  - Latency: with the request seen at edge E0, data is registered at edge E0+WAIT_CYCLES and valid from the following cycle. For WAIT_CYCLES = 2, this fits the control unit's 3-cycle Mem_OE window with LD_MDR on the third cycle.
- WR:
  - CE_N = 0, WE_N = 0 (unless io_hit), DQ_oe = 1, SRAM_DQ_out = latched data.
  - At counter == WAIT_CYCLES-1:
    - WE_N <= 1.
    - If io_hit, HEX_data <= latched data.
    - Go to WR_HOLD.
- WR_HOLD: one cycle with CE_N = 0, WE_N = 1, DQ_oe = 1 (data hold after WE rise). Then CE_N <= 1, DQ_oe <= 0, go to DONE.
- DONE: stay until Mem_OE = 0 and Mem_WE = 0, then go to IDLE.
  - A request held high past completion never triggers a second access.
  - Back-to-back accesses need at least one cycle with both requests low.
- Requests dropping mid-RD/WR are ignored; the access completes with its full timing.
- WE_N and OE_N are never both 0. DQ_oe = 1 never coincides with OE_N = 0.
- Data_to_CPU holds its last value between reads. ADDR/Data_from_CPU changes after latch have no effect on the current access.

Test Plan:
1. SRAM read, WAIT_CYCLES = 2, ADDR = 0x00123, SRAM model returns 0xBEEF:
   - OE_N/CE_N low for exactly 2 cycles.
   - Data_to_CPU = 0xBEEF with a single-cycle Data_valid.
   - Mem_OE held 3 cycles causes no second access.
2. SRAM write, ADDR = 0x00040, data 0x1234:
   - WE_N low for 2 cycles, DQ_oe high 3 cycles (through hold), DQ_out = 0x1234.
   - Model holds 0x1234 at 0x40; a subsequent read returns 0x1234.
3. I/O accesses:
   - Write 0x00AB to IO_ADDR: HEX_data = 0x00AB, CE_N/WE_N never low.
   - Read IO_ADDR with Switches = 0x5A5A: Data_to_CPU = 0x5A5A, OE_N never low.
4. Simultaneous Mem_OE = Mem_WE = 1 in IDLE: write performed, no OE_N pulse, Data_valid stays 0.
5. Reset asserted during cycle 1 of WR:
   - Next cycle WE_N = 1, CE_N = 1, DQ_oe = 0, state IDLE, HEX_data = 0.
   - A fresh read afterwards behaves as in scenario 1.
6. WAIT_CYCLES = 4 build, ADDR changed mid-read:
   - OE_N low 4 cycles.
   - SRAM_ADDR stays at the latched value.
   - Data_valid fires 4 edges after the request edge.
